// File: rtl/calc_host_pkg.sv
// Shared types and constants for the calculator host controller: state
// encoding, the page-flush branch instruction, ROM page indices and command codes.
package calc_host_pkg;

  typedef enum logic [3:0] {
    IDLE, OP1, OP2, OP3, RUN, OTH1, OTH2, OTH3, INR,
    RETW1, RETR1, RETW2, RETR2, RET, PAGING
  } state_e;

  // Branch-to-0 fed to the core while a page swap is in flight
  localparam logic [7:0] BRANCH0 = 8'b1000_0000;

  localparam int PAGE_LINK = 0;
  localparam int PAGE_ADD  = 1;
  localparam int PAGE_SUB  = 2;
  localparam int PAGE_MUL  = 3;
  localparam int PAGE_DIV  = 4;

  localparam logic [3:0] CMD_ADD = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_MUL = 4'b0100;
  localparam logic [3:0] CMD_DIV = 4'b1000;

  function automatic logic is_cmd(input logic [3:0] c);
    return (c == CMD_ADD) || (c == CMD_SUB) || (c == CMD_MUL) || (c == CMD_DIV);
  endfunction

endpackage

// File: rtl/calc_page_mux.sv
// ROM page selector feeding the core instruction bus; force_i substitutes
// the branch-to-0 instruction so the core parks at PC 0 during a page swap.
module calc_page_mux
  import calc_host_pkg::*;
#(
  parameter int INSTR_LEN = 8,
  parameter int NUM_PAGES = 5,
  parameter int PW        = 3
) (
  input  logic [NUM_PAGES*INSTR_LEN-1:0] rom_data_i,
  input  logic [PW-1:0]                  page_sel_i,
  input  logic                           force_i,
  output logic [INSTR_LEN-1:0]           instr_o
);

  always_comb begin
    instr_o = '0;
    for (int p = 0; p < NUM_PAGES; p++) begin
      if (page_sel_i == PW'(p)) instr_o = rom_data_i[p*INSTR_LEN +: INSTR_LEN];
    end
    if (force_i) instr_o = INSTR_LEN'(BRANCH0);
  end

endmodule

// File: rtl/calc_host_ctrl.sv
// Host-side sequencer for the calculator core: decodes 2-bit symbols from the
// core output port, swaps ROM pages, feeds operands/commands and collects results.
// Optional RUN watchdog enabled by defining CALC_HOST_TIMEOUT_EN.
module calc_host_ctrl
  import calc_host_pkg::*;
#(
  parameter int DATA_LEN  = 4,
  parameter int PC_LEN    = 7,
  parameter int INSTR_LEN = 8,
  parameter int NUM_PAGES = 5
`ifdef CALC_HOST_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 4096
`endif
) (
  input  logic                           CLK,
  input  logic                           RSTN,
  input  logic [DATA_LEN-1:0]            OPORT,
  input  logic [PC_LEN-1:0]              PC,
  output logic [DATA_LEN-1:0]            IPORT,
  input  logic [NUM_PAGES*INSTR_LEN-1:0] rom_data,
  output logic [INSTR_LEN-1:0]           INSTR,
  output logic [$clog2(NUM_PAGES)-1:0]   page_sel,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_LEN-1:0]            in_data,
  output logic                           res_valid,
  output logic [2*DATA_LEN-1:0]          res_data,
  output logic                           res_is_div,
  output logic                           underrun,
  output logic                           cmd_err,
  output logic                           timeout
);

  localparam int PW = $clog2(NUM_PAGES);

  state_e                state_q, state_d, dst_q, dst_d;
  logic [PW-1:0]         page_q, page_d;
  logic [DATA_LEN-1:0]   iport_q, iport_d, lo_q, lo_d;
  logic [2*DATA_LEN-1:0] res_data_q, res_data_d;
  logic                  res_valid_q, res_valid_d, res_is_div_q, res_is_div_d;
  logic                  div_q, div_d, underrun_q, underrun_d, cmd_err_q, cmd_err_d;
  logic                  req, pop, pop_cmd;
  logic [PW-1:0]         req_page;
  state_e                req_dst;
  logic [1:0]            sym;

`ifdef CALC_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          timeout_q, timeout_d;
`endif

  assign sym = OPORT[1:0];

  always_comb begin
    state_d      = state_q;
    dst_d        = dst_q;
    page_d       = page_q;
    iport_d      = iport_q;
    lo_d         = lo_q;
    res_data_d   = res_data_q;
    res_valid_d  = 1'b0;
    res_is_div_d = res_is_div_q;
    div_d        = div_q;
    underrun_d   = underrun_q;
    cmd_err_d    = cmd_err_q;
    req          = 1'b0;
    req_page     = PW'(PAGE_LINK);
    req_dst      = RUN;
    pop          = 1'b0;
    pop_cmd      = 1'b0;
    in_ready     = 1'b0;
`ifdef CALC_HOST_TIMEOUT_EN
    tmr_d        = tmr_q;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      IDLE:   if (sym == 2'd1) state_d = OP1; else if (sym == 2'd2) state_d = OTH1;
      OP1:    if (sym == 2'd0) state_d = OP2; else if (sym == 2'd2) state_d = OP3;
      OP2: begin
        if (sym == 2'd1) begin req = 1'b1; req_page = PW'(PAGE_ADD); end
        else if (sym == 2'd2) begin req = 1'b1; req_page = PW'(PAGE_DIV); div_d = 1'b1; end
      end
      OP3: begin
        if (sym == 2'd1) begin req = 1'b1; req_page = PW'(PAGE_MUL); end
        else if (sym == 2'd0) begin req = 1'b1; req_page = PW'(PAGE_SUB); end
      end
      RUN: begin
        if (sym == 2'd3) state_d = IDLE;
`ifdef CALC_HOST_TIMEOUT_EN
        else if (tmr_q == '0) begin
          timeout_d = 1'b1;
          req       = 1'b1;
          req_dst   = IDLE;
        end else tmr_d = tmr_q - 1'b1;
`endif
      end
      OTH1:   if (sym == 2'd0) state_d = OTH2; else if (sym == 2'd1) state_d = OTH3;
      OTH2: begin
        if (sym == 2'd2) state_d = RETW1;
        else if (sym == 2'd1) pop = 1'b1;
      end
      OTH3: begin
        if (sym == 2'd0) pop = 1'b1;
        else if (sym == 2'd2) begin pop = 1'b1; pop_cmd = 1'b1; end
      end
      INR:    if (sym == 2'd3) state_d = IDLE;
      RETW1:  state_d = RETR1;
      RETR1:  begin lo_d = OPORT; state_d = RETW2; end
      RETW2:  state_d = RETR2;
      RETR2: begin
        res_data_d   = {OPORT, lo_q};
        res_valid_d  = 1'b1;
        res_is_div_d = div_q;
        div_d        = 1'b0;
        req          = 1'b1;
        req_dst      = RET;
      end
      RET:    if (sym == 2'd3) state_d = IDLE;
      PAGING: begin
        if (PC == '0) begin
          state_d = dst_q;
`ifdef CALC_HOST_TIMEOUT_EN
          tmr_d = TW'(TIMEOUT - 1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (req) begin
      page_d  = req_page;
      dst_d   = req_dst;
      state_d = PAGING;
    end

    // A failed pop still hands the core a legal word (ADD / 1) so it never stalls
    if (pop) begin
      in_ready = 1'b1;
      state_d  = INR;
      if (!in_valid) begin
        iport_d    = DATA_LEN'(1);
        underrun_d = 1'b1;
      end else if (pop_cmd && !is_cmd(in_data[3:0])) begin
        iport_d   = DATA_LEN'(CMD_ADD);
        cmd_err_d = 1'b1;
      end else begin
        iport_d = in_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      dst_q        <= IDLE;
      page_q       <= '0;
      iport_q      <= '0;
      lo_q         <= '0;
      res_data_q   <= '0;
      res_valid_q  <= 1'b0;
      res_is_div_q <= 1'b0;
      div_q        <= 1'b0;
      underrun_q   <= 1'b0;
      cmd_err_q    <= 1'b0;
`ifdef CALC_HOST_TIMEOUT_EN
      tmr_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      dst_q        <= dst_d;
      page_q       <= page_d;
      iport_q      <= iport_d;
      lo_q         <= lo_d;
      res_data_q   <= res_data_d;
      res_valid_q  <= res_valid_d;
      res_is_div_q <= res_is_div_d;
      div_q        <= div_d;
      underrun_q   <= underrun_d;
      cmd_err_q    <= cmd_err_d;
`ifdef CALC_HOST_TIMEOUT_EN
      tmr_q        <= tmr_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

`ifdef CALC_HOST_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign page_sel   = page_q;
  assign IPORT      = iport_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_is_div = res_is_div_q;
  assign underrun   = underrun_q;
  assign cmd_err    = cmd_err_q;

  calc_page_mux #(
    .INSTR_LEN (INSTR_LEN),
    .NUM_PAGES (NUM_PAGES),
    .PW        (PW)
  ) u_page_mux (
    .rom_data_i (rom_data),
    .page_sel_i (page_q),
    .force_i    ((state_q == PAGING) && (PC != '0)),
    .instr_o    (INSTR)
  );

endmodule

// File: doc/calc_host_ctrl.md
CALC_HOST_CTRL -- requirements
Module: calc_host_ctrl

Interface
REQ-001 SHALL have parameter DATA_LEN, default 4, meaning core data-port width.
REQ-002 SHALL have parameter PC_LEN, default 7, meaning core PC width.
REQ-003 SHALL have parameter INSTR_LEN, default 8, meaning instruction width.
REQ-004 SHALL have parameter NUM_PAGES, default 5, meaning number of ROM pages; it SHALL be at least 5.
REQ-005 SHALL have port CLK, input, width 1, the single clock; RSTN, input, width 1, reset that is synchronous and active-low.
REQ-006 SHALL have ports OPORT input DATA_LEN (core output port); PC input PC_LEN (core PC); IPORT output DATA_LEN (core input port).
REQ-007 SHALL have ports rom_data input NUM_PAGES*INSTR_LEN (page p in slice p); INSTR output INSTR_LEN (to core); page_sel output clog2(NUM_PAGES).
REQ-008 SHALL have ports in_valid input 1, in_ready output 1, in_data input DATA_LEN, forming the operand/command source.
REQ-009 SHALL have ports res_valid output 1, res_data output 2*DATA_LEN, res_is_div output 1, underrun output 1, cmd_err output 1, timeout output 1.

Function
REQ-010 SHALL sample sym=OPORT[1:0] each posedge; states IDLE,OP1,OP2,OP3,RUN,OTH1,OTH2,OTH3,INR,RETW1,RETR1,RETW2,RETR2,RET,PAGING.
REQ-011 IDLE: sym 1->OP1, 2->OTH1, else hold. OP1: 0->OP2, 2->OP3. OP2: 1->page ADD, 2->page DIV (set div flag). OP3: 1->page MUL, 0->page SUB.
REQ-012 Page request: page_sel<=target, state PAGING; INSTR SHALL equal constant BRANCH0 (1_000_0000) every cycle while PAGING and PC!=0; first cycle PC==0 releases force, state RUN (op pages) or RET (return to linkage).
REQ-013 RUN: sym 3->IDLE. OTH1: 0->OTH2, 1->OTH3. OTH2: 2->RETW1, 1->INR (operand). OTH3: 0->INR (operand), 2->INR (command). INR: sym 3->IDLE.
REQ-014 Entering INR SHALL pop one word: in_ready high exactly that cycle; IPORT<=in_data if in_valid; otherwise IPORT<=1 and underrun set (sticky).
REQ-015 Command pop: in_data not one-hot (low 4 bits) SHALL drive IPORT<=0001 (add) and set cmd_err (sticky).
REQ-016 Result: RETW1->RETR1 unconditional; RETR1 latches lo=OPORT; RETW2; RETR2 latches hi=OPORT, pulses res_valid 1 cycle with res_data={hi,lo}, res_is_div=div flag, clears div flag, then pages to page 0.
REQ-017 RET: sym 3->IDLE. Outside PAGING, INSTR SHALL be rom_data slice page_sel, combinationally.
REQ-018 Symbol 3 in IDLE, or any undecoded symbol, SHALL hold state.

Reset
REQ-019 RSTN low at posedge: state IDLE, page_sel 0, IPORT 0, force off, res_valid 0, res_data 0, div flag 0, all sticky flags 0; reset mid-PAGING SHALL drop force on that edge.

Configuration
REQ-020 Macro CALC_HOST_TIMEOUT_EN: when defined, a counter (parameter TIMEOUT, default 4096) counts RUN cycles; expiry SHALL set timeout (sticky) and page to page 0 via PAGING, then IDLE. When undefined, timeout SHALL be tied 0 and no counter SHALL exist.

Structure
REQ-021 Package calc_host_pkg SHALL hold state enum, BRANCH0, page indices (LINK=0, ADD=1, SUB=2, MUL=3, DIV=4), and command codes (0001 add, 0010 sub, 0100 mul, 1000 div).
REQ-022 Sub-module calc_page_mux SHALL implement page select plus BRANCH0 override.

Verification
REQ-023 Symbols 1,0,1 with PC=0x12 -> INSTR=0x80 until PC=0, page_sel=1, state RUN.
REQ-024 Symbols 1,0,2, then 2,0,2, OPORT lo=0x3, hi=0x1 -> res_valid once, res_data=0x13, res_is_div=1, page_sel returns to 0.
REQ-025 Symbols 2,0,1 with in_valid=0 -> IPORT=0x1, underrun=1, in_ready pulsed once.
REQ-026 Symbols 2,1,2 with in_data=0x6 -> IPORT=0x1, cmd_err=1.
REQ-027 RSTN low during PAGING with PC=0x05 -> next cycle INSTR=rom page 0, page_sel=0, state IDLE.
REQ-028 With CALC_HOST_TIMEOUT_EN, TIMEOUT=16, RUN without symbol 3 for 16 cycles -> timeout=1, page_sel=0.
